// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared types and widths for the segment display arbiter
package seg_display_pkg;

  localparam int VALUE_W = 5;
  localparam int OWNER_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_LINGER = 2'd2
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// rtl/seg_display_arbiter_if.sv - requester/display bus bundle
interface seg_display_arbiter_if
  import seg_display_pkg::*;
#(
  parameter int N_REQ = 3
);

  logic [N_REQ-1:0]              i_valid;
  logic [N_REQ-1:0][VALUE_W-1:0] i_value;
  logic [N_REQ-1:0]              o_ready;
  logic [VALUE_W-1:0]            o_hex;
  logic                          o_blank;
  logic [OWNER_W-1:0]            o_owner;
  logic                          o_busy;

  modport master (
    output i_valid, i_value,
    input  o_ready, o_hex, o_blank, o_owner, o_busy
  );

  modport slave (
    input  i_valid, i_value,
    output o_ready, o_hex, o_blank, o_owner, o_busy
  );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin pick starting after the last index, optionally skipping it
module rr_picker
  import seg_display_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [OWNER_W-1:0] last,
  input  logic               excl_en,
  output logic [N_REQ-1:0]   gnt,
  output logic [OWNER_W-1:0] idx,
  output logic               any
);

  logic [OWNER_W-1:0] pos;

  // The final position visited is `last` itself, which is skipped when excluded.
  always_comb begin
    gnt = '0;
    idx = last;
    any = 1'b0;
    pos = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = OWNER_W'((int'(last) + k) % N_REQ);
      if (!any && req[pos] && !(excl_en && (k == N_REQ))) begin
        any      = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - arbitrates requesters onto a shared two-digit display with dwell and linger
module seg_display_arbiter
  import seg_display_pkg::*;
#(
  parameter int N_REQ         = 3,
  parameter int DWELL_CYCLES  = 50_000_000,
  parameter int LINGER_CYCLES = 250_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  seg_display_arbiter_if.slave bus
);

  localparam int DW = cnt_w(DWELL_CYCLES);
  localparam int LW = cnt_w(LINGER_CYCLES);
  localparam logic [DW-1:0] DWELL_LOAD  = DW'(DWELL_CYCLES - 1);
  localparam logic [LW-1:0] LINGER_LOAD = LW'(LINGER_CYCLES - 1);

  state_t                        state, state_n;
  logic [VALUE_W-1:0]            hex, hex_n;
  logic [OWNER_W-1:0]            owner, owner_n;
  logic [DW-1:0]                 dwell, dwell_n;
  logic [LW-1:0]                 linger, linger_n;
  logic [N_REQ-1:0]              ready;
  logic [N_REQ-1:0]              valid;
  logic [N_REQ-1:0][VALUE_W-1:0] value;
  logic [N_REQ-1:0]              pick_gnt;
  logic [OWNER_W-1:0]            pick_idx;
  logic                          pick_any;
  logic                          take_pick;
  logic                          take_owner;

  assign valid = bus.i_valid;
  assign value = bus.i_value;

  // Only a HOLD at dwell expiry needs the current owner excluded from the search.
  rr_picker #(.N_REQ(N_REQ)) u_rr_picker (
    .req     (valid),
    .last    (owner),
    .excl_en (state == ST_HOLD),
    .gnt     (pick_gnt),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      hex    <= '0;
      owner  <= OWNER_W'(N_REQ - 1);
      dwell  <= '0;
      linger <= '0;
    end else begin
      state  <= state_n;
      hex    <= hex_n;
      owner  <= owner_n;
      dwell  <= dwell_n;
      linger <= linger_n;
    end
  end

  always_comb begin
    state_n    = state;
    hex_n      = hex;
    owner_n    = owner;
    dwell_n    = dwell;
    linger_n   = linger;
    ready      = '0;
    take_pick  = 1'b0;
    take_owner = 1'b0;
    unique case (state)
      ST_IDLE: take_pick = pick_any;
      ST_HOLD: begin
        if (dwell != '0) begin
          dwell_n    = dwell - DW'(1);
          take_owner = valid[owner];
        end else if (pick_any) begin
          take_pick = 1'b1;
        end else if (valid[owner]) begin
          take_owner = 1'b1;
          dwell_n    = DWELL_LOAD;
        end else begin
          state_n  = ST_LINGER;
          linger_n = LINGER_LOAD;
        end
      end
      ST_LINGER: begin
        if (pick_any) begin
          take_pick = 1'b1;
        end else if (linger == '0) begin
          state_n = ST_IDLE;
        end else begin
          linger_n = linger - LW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (take_pick) begin
      ready   = pick_gnt;
      hex_n   = value[pick_idx];
      owner_n = pick_idx;
      dwell_n = DWELL_LOAD;
      state_n = ST_HOLD;
    end else if (take_owner) begin
      ready[owner] = 1'b1;
      hex_n        = value[owner];
    end

    // No transfer may complete while reset is held.
    if (!i_rst_n) ready = '0;
  end

  assign bus.o_ready = ready;
  assign bus.o_hex   = hex;
  assign bus.o_owner = owner;
  assign bus.o_blank = (state == ST_IDLE);
  assign bus.o_busy  = (state == ST_HOLD);

endmodule
